// File: rtl/seg7_display_arbiter_pkg.sv
// Shared types and constants for the two-client 7-segment display arbiter.
package seg7_display_arbiter_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned DATA_W     = NUM_DIGITS * NIBBLE_W;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned HOLD_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [NUM_DIGITS-1:0] blank;
  } shadow_t;

  localparam logic [SEG_W-1:0] BLANK_SEG = 7'h7F;

  // Active-low segment patterns, entry [n] is hex digit n (F listed first).
  localparam logic [15:0][SEG_W-1:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_display_arbiter_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decode
  import seg7_display_arbiter_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    seg_c
);

  assign seg_c = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_display_arbiter.sv
// Scans a 4-digit multiplexed display and hands it between two clients,
// switching owner only at frame boundaries so a frame never tears.
module seg7_display_arbiter
  import seg7_display_arbiter_pkg::*;
#(
  parameter int unsigned SCAN_BITS   = 15,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic [DATA_W-1:0]     data_a,
  input  logic [NUM_DIGITS-1:0] blank_a,
  input  logic                  req_b,
  input  logic [DATA_W-1:0]     data_b,
  input  logic [NUM_DIGITS-1:0] blank_b,
  output logic                  grant_a,
  output logic                  grant_b,
  output logic                  frame_tick,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      seg
);

  localparam int unsigned SCAN_W = SCAN_BITS + 2;
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(HOLD_FRAMES - 1);
  localparam shadow_t SHADOW_IDLE = '{data: '0, blank: '1};

  logic [SCAN_W-1:0]     scan_q, scan_d;
  state_e                state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  shadow_t               shadow_q, shadow_d;
  logic                  grant_a_q, grant_a_d;
  logic                  grant_b_q, grant_b_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;

  logic                  frame_end_c;
  logic [1:0]            digit_sel_c;
  logic [NIBBLE_W-1:0]   nibble_c;
  logic [SEG_W-1:0]      hex_seg_c;

  assign digit_sel_c = scan_q[SCAN_W-1 -: 2];
  assign frame_end_c = &scan_q;
  assign nibble_c    = NIBBLE_W'(shadow_q.data >> {digit_sel_c, 2'b00});

  seg7_hex_decode u_hex_decode (
    .nibble (nibble_c),
    .seg_c  (hex_seg_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q       <= '0;
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      shadow_q     <= SHADOW_IDLE;
      grant_a_q    <= 1'b0;
      grant_b_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= BLANK_SEG;
    end else begin
      scan_q       <= scan_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      shadow_q     <= shadow_d;
      grant_a_q    <= grant_a_d;
      grant_b_q    <= grant_b_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  // Ownership decision, only taken in the last cycle of a frame.
  always_comb begin
    state_d = state_q;
    if (frame_end_c) begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_a)      state_d = ST_OWN_A;
          else if (req_b) state_d = ST_OWN_B;
        end
        ST_OWN_A: begin
          if (!req_a)                            state_d = req_b ? ST_OWN_B : ST_IDLE;
          else if (req_b && hold_q >= HOLD_LIMIT) state_d = ST_OWN_B;
        end
        ST_OWN_B: begin
          if (!req_b)                            state_d = req_a ? ST_OWN_A : ST_IDLE;
          else if (req_a && hold_q >= HOLD_LIMIT) state_d = ST_OWN_A;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Scan, hold, shadow and pin drive next values.
  always_comb begin
    scan_d       = scan_q + SCAN_W'(1);
    hold_d       = hold_q;
    shadow_d     = shadow_q;
    frame_tick_d = frame_end_c;
    grant_a_d    = (state_d == ST_OWN_A);
    grant_b_d    = (state_d == ST_OWN_B);
    an_d         = ~(NUM_DIGITS'(1) << digit_sel_c);
    seg_d        = hex_seg_c;

    if (frame_end_c) begin
      if (state_d != state_q)  hold_d = '0;
      else if (hold_q != '1)   hold_d = hold_q + HOLD_W'(1);

      unique case (state_d)
        ST_OWN_A: shadow_d = '{data: data_a, blank: blank_a};
        ST_OWN_B: shadow_d = '{data: data_b, blank: blank_b};
        default:  shadow_d = SHADOW_IDLE;
      endcase
    end

    if (shadow_q.blank[digit_sel_c]) begin
      an_d  = '1;
      seg_d = BLANK_SEG;
    end
  end

  assign grant_a    = grant_a_q;
  assign grant_b    = grant_b_q;
  assign frame_tick = frame_tick_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Scoreboard bench: per-frame expectations queued by stimulus, checked by a monitor.
module tb_seg7_display_arbiter;

  typedef struct packed {
    logic            ga;
    logic            gb;
    logic [3:0][3:0] an;
    logic [3:0][6:0] seg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [15:0] data_a = '0, data_b = '0;
  logic [3:0]  blank_a = '0, blank_b = '0;
  logic        grant_a, grant_b, frame_tick;
  logic [3:0]  an;
  logic [6:0]  seg;

  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  exp_t sb_q[$];

  seg7_display_arbiter #(.SCAN_BITS(2), .HOLD_FRAMES(2)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .blank_a(blank_a),
    .req_b(req_b), .data_b(data_b), .blank_b(blank_b),
    .grant_a(grant_a), .grant_b(grant_b), .frame_tick(frame_tick),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic exp_t make_exp(input logic ga, input logic gb,
                                    input logic [15:0] d, input logic [3:0] b);
    exp_t e;
    e.ga = ga;
    e.gb = gb;
    for (int i = 0; i < 4; i++) begin
      e.an[i]  = b[i] ? 4'hF : ~(4'b0001 << i);
      e.seg[i] = b[i] ? 7'h7F : hex_seg(d[4*i +: 4]);
    end
    return e;
  endfunction

  task automatic wait_tick();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (frame_tick) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_tick: frame_tick not seen within 40 cycles at %0t", $time);
  endtask

  // Called at the start of frame k: change inputs mid-frame, expect frame k+1.
  task automatic step(input logic ra, input logic [15:0] da, input logic [3:0] ba,
                      input logic rb, input logic [15:0] db, input logic [3:0] bb,
                      input exp_t e);
    wait_tick();
    repeat (8) @(negedge clk);
    req_a = ra; data_a = da; blank_a = ba;
    req_b = rb; data_b = db; blank_b = bb;
    sb_q.push_back(e);
  endtask

  // Monitor: one observation per frame, four digit samples mid-dwell.
  initial begin
    exp_t obs, e;
    int   frame = 0;
    forever begin
      @(negedge clk);
      if (mon_en && frame_tick) begin
        frame++;
        obs = '0;
        obs.ga = grant_a;
        obs.gb = grant_b;
        for (int d = 0; d < 4; d++) begin
          repeat ((d == 0) ? 2 : 4) @(negedge clk);
          obs.an[d]  = an;
          obs.seg[d] = seg;
        end
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: frame %0d observed with no expectation", frame);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("grants_f%0d", frame), 32'({obs.ga, obs.gb}), 32'({e.ga, e.gb}));
          check($sformatf("an_f%0d", frame), 32'(obs.an), 32'(e.an));
          check($sformatf("seg_f%0d", frame), 32'(obs.seg), 32'(e.seg));
        end
      end
    end
  end

  // Grants exclusive every cycle; frame_tick period is 16 cycles.
  int  tick_cyc = 0;
  bit  tick_seen = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      tick_cyc  = 0;
      tick_seen = 1'b0;
    end else begin
      check("grant_exclusive", 32'(grant_a & grant_b), 32'd0);
      tick_cyc++;
      if (frame_tick) begin
        if (tick_seen && mon_en) check("tick_period", 32'(tick_cyc), 32'd16);
        tick_seen = 1'b1;
        tick_cyc  = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst = 1'b1;
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_grants", 32'({grant_a, grant_b}), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);

    req_a = 1'b1; data_a = 16'h1234;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (grant_a) break;
    end
    check("first_grant_latency", 32'(n), 32'd16);

    // Asynchronous reset while A is displaying digit 0.
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_grants", 32'({grant_a, grant_b}), 32'd0);
    @(negedge clk);
    req_a = 1'b0; data_a = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    sb_q.push_back(make_exp(1'b0, 1'b0, 16'h0, 4'hF));

    step(0, 16'h0000, 4'h0, 0, 16'h0000, 4'h0, make_exp(0, 0, 16'h0000, 4'hF));
    step(0, 16'h0000, 4'h0, 0, 16'h0000, 4'h0, make_exp(0, 0, 16'h0000, 4'hF));
    step(1, 16'h1234, 4'h0, 0, 16'h0000, 4'h0, make_exp(1, 0, 16'h1234, 4'h0));
    step(1, 16'hABCD, 4'h0, 0, 16'h0000, 4'h0, make_exp(1, 0, 16'hABCD, 4'h0));
    step(1, 16'hABCD, 4'h0, 1, 16'h0F9E, 4'h0, make_exp(0, 1, 16'h0F9E, 4'h0));
    step(1, 16'hABCD, 4'h0, 1, 16'h0F9E, 4'h0, make_exp(0, 1, 16'h0F9E, 4'h0));
    step(1, 16'hABCD, 4'h0, 1, 16'h0F9E, 4'h0, make_exp(1, 0, 16'hABCD, 4'h0));
    step(1, 16'hABCD, 4'h0, 1, 16'h0F9E, 4'h0, make_exp(1, 0, 16'hABCD, 4'h0));
    step(1, 16'h1234, 4'hC, 0, 16'h0000, 4'h0, make_exp(1, 0, 16'h1234, 4'hC));
    step(0, 16'h1234, 4'hC, 0, 16'h0000, 4'h0, make_exp(0, 0, 16'h0000, 4'hF));
    step(0, 16'h0000, 4'h0, 0, 16'h0000, 4'h0, make_exp(0, 0, 16'h0000, 4'hF));

    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain: %0d expectations left unchecked", sb_q.size());
    end
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
